// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, counter width
// and the load-use hazard detector.
package hazard_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

  // The EX-stage load writes a register the ID-stage instruction reads; x0 never hazards.
  function automatic logic load_use(input logic       mem_rd,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return mem_rd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// In-order pipeline hazard controller: load-use stalls, branch flushes and
// multi-cycle MDU stalls with a timeout, plus stall/flush performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_m_bubble,
  output logic             mdu_abort,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMR_LAST  = 8'(MDU_TIMEOUT - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] fl_q, fl_d;
  logic [7:0] tmr_q, tmr_d;
  logic       stall_inc, flush_inc;
  logic       hazard;

  assign hazard = load_use(id_ex_mem_read, id_ex_rd, id_rs1, id_rs2);

  always_comb begin
    state_d     = state_q;
    fl_d        = fl_q;
    tmr_d       = tmr_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_bubble = 1'b0;
    mdu_abort   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fl_d    = FL_RELOAD;
          end
        end else if (mdu_start && !mdu_done) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          ex_m_bubble = 1'b1;
          state_d     = MDU_WAIT;
          tmr_d       = '0;
        end else if (hazard) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end

      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        // fl_q counts the FLUSH cycles still owed, including this one.
        if (branch_taken) begin
          fl_d      = FL_RELOAD;
          flush_inc = 1'b1;
        end else if (fl_q <= 3'd1) begin
          fl_d    = '0;
          state_d = RUN;
        end else begin
          fl_d = fl_q - 3'd1;
        end
      end

      MDU_WAIT: begin
        stall_inc = 1'b1;
        if (mdu_done) begin
          state_d = RUN;
        end else if (tmr_q == TMR_LAST) begin
          mdu_abort = 1'b1;
          state_d   = RUN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          ex_m_bubble = 1'b1;
          tmr_d       = tmr_q + 8'd1;
        end
      end

      default: state_d = RUN;
    endcase

    // Reset freezes the pipe with NOPs everywhere, independent of the clock.
    if (arst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_m_bubble = 1'b1;
      mdu_abort   = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= RUN;
      fl_q    <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      tmr_q   <= tmr_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .arst  (arst),
    .en    (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .arst  (arst),
    .en    (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized and directed checking of hazard_controller against a cycle-level
// reference model of the pipeline control rules.
module tb_hazard_controller;

  localparam int FC = 3;
  localparam int TO = 8;

  // Output vector order: {pc, if_id_w, id_ex_w, if_id_fl, id_ex_fl, bubble, abort}
  localparam logic [6:0] O_IDLE  = 7'b1110000;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_STALL = 7'b0000010;
  localparam logic [6:0] O_LU    = 7'b0010100;
  localparam logic [6:0] O_ABORT = 7'b1110001;
  localparam logic [6:0] O_RST   = 7'b0001110;

  logic        clk = 1'b0;
  logic        arst;
  logic [4:0]  id_rs1, id_rs2, id_ex_rd;
  logic        id_ex_mem_read, branch_taken, mdu_start, mdu_done;
  logic        pc_write, if_id_write, id_ex_write;
  logic        if_id_flush, id_ex_flush, ex_m_bubble, mdu_abort;
  logic [31:0] stall_cnt, flush_cnt;
  logic        sc_en;
  logic [2:0]  sc_cnt;

  int          n_chk = 0;
  int          n_fail = 0;

  // Reference model state: FLUSH cycles still owed, MDU wait age (-1 = idle).
  int          flush_rem = 0;
  int          wait_age = -1;
  logic [31:0] m_st = 0, m_fl = 0;
  logic [6:0]  o_last;

  always #5 clk = ~clk;

  hazard_controller #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_m_bubble(ex_m_bubble), .mdu_abort(mdu_abort),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  sat_counter #(.WIDTH(3)) u_sc (.clk(clk), .arst(arst), .en(sc_en), .count(sc_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock cycle: drive just after a rising edge, check at the falling edge.
  task automatic cycle(input logic rst, input logic br, input logic st, input logic dn,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    logic [6:0] e, got;
    arst = rst; branch_taken = br; mdu_start = st; mdu_done = dn;
    id_ex_mem_read = mr; id_ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    @(negedge clk);
    got = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_m_bubble, mdu_abort};
    if (rst) begin
      flush_rem = 0; wait_age = -1; m_st = 0; m_fl = 0;
    end
    chk("stall_cnt", stall_cnt, m_st);
    chk("flush_cnt", flush_cnt, m_fl);
    if (rst) e = O_RST;
    else if (flush_rem > 0) begin
      e = O_FLUSH;
      if (br) begin flush_rem = FC - 1; m_fl = sat_inc(m_fl); end
      else flush_rem--;
    end else if (wait_age >= 0) begin
      m_st = sat_inc(m_st);
      if (dn) begin e = O_IDLE; wait_age = -1; end
      else if (wait_age == TO - 1) begin e = O_ABORT; wait_age = -1; end
      else begin e = O_STALL; wait_age++; end
    end else if (br) begin
      e = O_FLUSH; m_fl = sat_inc(m_fl); flush_rem = FC - 1;
    end else if (st && !dn) begin
      e = O_STALL; wait_age = 0;
    end else if (mr && rd != 0 && (rd == rs1 || rd == rs2)) begin
      e = O_LU; m_st = sat_inc(m_st);
    end else e = O_IDLE;
    chk("outs", {25'd0, got}, {25'd0, e});
    o_last = got;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    int n, first;
    arst = 1'b1; sc_en = 1'b0;
    branch_taken = 0; mdu_start = 0; mdu_done = 0; id_ex_mem_read = 0;
    id_ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_outs", {25'd0, o_last}, {25'd0, O_RST});

    // Saturating counter boundary on a narrow instance.
    sc_en = 1'b1;
    repeat (3) idle();
    chk("sat_mid", {29'd0, sc_cnt}, 32'd3);
    repeat (7) idle();
    chk("sat_top", {29'd0, sc_cnt}, 32'd7);
    sc_en = 1'b0;

    // Load-use on rs2.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5);
    chk("lu_pc", {31'd0, o_last[6]}, 32'd0);
    chk("lu_flush", {31'd0, o_last[2]}, 32'd1);
    idle();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_release", {25'd0, o_last}, {25'd0, O_IDLE});

    // Same with rd = x0: no hazard.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("x0_outs", {25'd0, o_last}, {25'd0, O_IDLE});
    idle();
    chk("x0_stall_cnt", stall_cnt, 32'd0);

    // Branch flush length.
    do_reset();
    n = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    n += o_last[3];
    repeat (5) begin idle(); n += o_last[3]; end
    chk("br_flush_len", n, FC);
    chk("br_flush_cnt", flush_cnt, 32'd1);

    // MDU completes four cycles after start.
    do_reset();
    n = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    n += !o_last[6];
    repeat (3) begin idle(); n += !o_last[6]; end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    n += !o_last[6];
    chk("mdu_stall_len", n, 4);
    idle();
    chk("mdu_stall_cnt", stall_cnt, 32'd4);

    // MDU timeout.
    do_reset();
    first = -1; n = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (o_last[0]) begin n++; if (first < 0) first = k; end
    end
    chk("abort_at", first, TO);
    chk("abort_pulses", n, 1);
    chk("abort_run", {25'd0, o_last}, {25'd0, O_IDLE});

    // Reset in the middle of an MDU wait.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(); idle();
    arst = 1'b1; #1;
    chk("rst_async_outs",
        {25'd0, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_m_bubble, mdu_abort},
        {25'd0, O_RST});
    do_reset();
    idle();
    chk("rst_mid_run", {25'd0, o_last}, {25'd0, O_IDLE});
    chk("rst_mid_stall_cnt", stall_cnt, 32'd0);

    // Randomized traffic with occasional asynchronous reset.
    repeat (600) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
